// File: rtl/localbus_uart_tx_pkg.sv
// Shared register map, status bit positions, bus write encodings and FSM state codes
// for the local-bus UART transmitter.
package localbus_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [2:0] WE_READ = 3'b000;
  localparam logic [2:0] WE_BYTE = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_WORD = 3'b100;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Divider values 0 and 1 both mean one clock per bit; the baud counter compares against len-1.
  function automatic logic [15:0] bit_len_m1(input logic [15:0] div);
    return (div <= 16'd1) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/localbus_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only if a pop
// happens in the same cycle, so it can be reused unchanged for a receive path.
module localbus_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/localbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory local bus: register decode,
// TX FIFO, per-frame latched baud divider and the start/data/stop serialiser.
module localbus_uart_tx
  import localbus_uart_tx_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] qin,
  input  logic [2:0]      we,
  output logic [XLEN-1:0] qout,
  output logic            uart_txd,
  output logic            tx_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      reg_sel;
  logic            bus_wr, bus_rd, push, pop;
  logic [7:0]      fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] status, rdata;
  logic            tick, go;
  logic            unused_bits;

  logic [XLEN-1:0] qout_q, qout_d;
  logic [15:0]     baud_q, baud_d;
  logic            en_q, en_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     len_q, len_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            irq_q, irq_d;

  assign reg_sel     = addr[3:2];
  assign bus_wr      = sel && (we != WE_READ);
  assign bus_rd      = sel && (we == WE_READ);
  assign push        = bus_wr && (reg_sel == REG_TXDATA);
  assign unused_bits = ^{addr[XLEN-1:4], addr[1:0], qin[XLEN-1:16]};

  localbus_uart_tx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (qin[7:0]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    baud_d = baud_q;
    en_d   = en_q;
    ovf_d  = ovf_q;
    if (bus_wr) begin
      case (reg_sel)
        REG_STATUS:  if (qin[ST_OVF]) ovf_d = 1'b0;
        REG_BAUDDIV: begin
          if (we == WE_BYTE) baud_d[7:0] = qin[7:0];
          else if (we == WE_HALF || we == WE_WORD) baud_d = qin[15:0];
        end
        REG_CTRL:    en_d = qin[0];
        default:     ;
      endcase
    end
    // A pop in the same cycle frees a slot, so only an unmatched push into a full FIFO overflows.
    if (push && fifo_full && !pop) ovf_d = 1'b1;

    status                       = '0;
    status[ST_FULL]              = fifo_full;
    status[ST_EMPTY]             = fifo_empty;
    status[ST_BUSY]              = (state_q != S_IDLE);
    status[ST_OVF]               = ovf_q;
    status[ST_COUNT_LSB +: CW]   = fifo_count;

    case (reg_sel)
      REG_STATUS:  rdata = status;
      REG_BAUDDIV: rdata = XLEN'(baud_q);
      REG_CTRL:    rdata = XLEN'(en_q);
      default:     rdata = '0;
    endcase
    qout_d = bus_rd ? rdata : '0;
  end

  assign tick = (cnt_q == len_q);
  assign go   = en_q && !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    len_d   = len_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (go) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          len_d   = bit_len_m1(baud_q);
          state_d = S_START;
        end
      end
      S_START: if (tick) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (tick) begin
        cnt_d   = '0;
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      default: if (tick) begin
        cnt_d = '0;
        // Chaining straight into the next start bit keeps back-to-back frames gapless.
        if (go) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          len_d   = bit_len_m1(baud_q);
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    irq_d = fifo_empty && (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qout_q  <= '0;
      baud_q  <= 16'(CLKS_PER_BIT);
      en_q    <= 1'b1;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      qout_q  <= qout_d;
      baud_q  <= baud_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      irq_q   <= irq_d;
    end
  end

  assign qout     = qout_q;
  assign uart_txd = txd_q;
  assign tx_irq   = irq_q;

endmodule

// File: tb/tb_localbus_uart_tx.sv
// Self-checking bench for localbus_uart_tx: bus register checks plus a serial-line
// monitor that decodes frames and compares them against a scoreboard of pushed bytes.
module tb_localbus_uart_tx;

  localparam logic [1:0] R_TXDATA  = 2'd0;
  localparam logic [1:0] R_STATUS  = 2'd1;
  localparam logic [1:0] R_BAUDDIV = 2'd2;
  localparam logic [1:0] R_CTRL    = 2'd3;
  localparam logic [2:0] W_BYTE    = 3'b001;
  localparam logic [2:0] W_HALF    = 3'b010;
  localparam logic [2:0] W_WORD    = 3'b100;

  typedef struct {
    logic [7:0] data;
    int         baud;
    bit         check;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] qin = '0;
  logic [2:0]  we = '0;
  logic [31:0] qout;
  logic        uart_txd;
  logic        tx_irq;

  int   cycle = 0;
  int   checkCount = 0;
  int   errCount = 0;
  int   lastWriteCycle = 0;
  int   base = 0;
  exp_t expQ[$];
  int   startTimes[$];

  exp_t       monE;
  logic [9:0] monBits;
  int         monT;

  logic [31:0] rd;

  localbus_uart_tx #(.XLEN(32), .FIFO_DEPTH(16), .CLKS_PER_BIT(868)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .addr     (addr),
    .qin      (qin),
    .we       (we),
    .qout     (qout),
    .uart_txd (uart_txd),
    .tx_irq   (tx_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge and returns at the next negedge.
  task automatic applyStimulus(input logic [1:0] regIdx, input logic [31:0] data, input logic [2:0] weCode);
    sel  = 1'b1;
    addr = 32'h4000_0000 | {28'h0, regIdx, 2'b00};
    qin  = data;
    we   = weCode;
    @(negedge clk);
    lastWriteCycle = cycle;
    sel = 1'b0;
    we  = '0;
    qin = '0;
  endtask

  task automatic readReg(input logic [1:0] regIdx, output logic [31:0] value);
    sel  = 1'b1;
    addr = 32'h4000_0000 | {28'h0, regIdx, 2'b00};
    we   = '0;
    @(negedge clk);
    value = qout;
    sel = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] data, input int baud, input bit record, input bit check);
    exp_t e;
    e.data  = data;
    e.baud  = baud;
    e.check = check;
    if (record) expQ.push_back(e);
    applyStimulus(R_TXDATA, {24'hFFFF_FF, data}, W_BYTE);
  endtask

  task automatic waitStarts(input int n, input int budget);
    int k = 0;
    while (startTimes.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("frames_started", startTimes.size(), n);
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (!(tx_irq === 1'b1 && expQ.size() == 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("idle_reached", {31'd0, tx_irq}, 1);
  endtask

  // Line monitor: decodes each frame at mid-bit using the divider the scoreboard expects for it.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && uart_txd === 1'b0) begin
        startTimes.push_back(cycle);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_frame", 1, 0);
          monE.data  = '0;
          monE.baud  = 1;
          monE.check = 1'b0;
        end else begin
          monE = expQ.pop_front();
        end
        monT = 0;
        for (int i = 0; i < 10; i++) begin
          while (monT < i * monE.baud + monE.baud / 2) begin
            @(negedge clk);
            monT++;
          end
          monBits[i] = uart_txd;
        end
        if (monE.check) begin
          checkOutput("start_bit", {31'd0, monBits[0]}, 0);
          checkOutput("frame_data", {24'd0, monBits[8:1]}, {24'd0, monE.data});
          checkOutput("stop_bit", {31'd0, monBits[9]}, 1);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_qout", qout, 0);
    checkOutput("rst_txd", {31'd0, uart_txd}, 1);
    checkOutput("rst_irq", {31'd0, tx_irq}, 1);
    rst = 1'b0;
    @(negedge clk);

    readReg(R_STATUS, rd);  checkOutput("status_reset", rd, 32'h0002);
    readReg(R_BAUDDIV, rd); checkOutput("bauddiv_reset", rd, 868);
    readReg(R_CTRL, rd);    checkOutput("ctrl_reset", rd, 1);
    @(negedge clk);
    checkOutput("qout_after_unsel", qout, 0);

    // A write with sel low must not push anything.
    addr = 32'h4000_0000; qin = 32'h55; we = W_WORD;
    @(negedge clk);
    we = '0;
    readReg(R_STATUS, rd);  checkOutput("status_unsel_write", rd, 32'h0002);

    applyStimulus(R_BAUDDIV, 32'h00AB_CD12, W_BYTE);
    readReg(R_BAUDDIV, rd); checkOutput("bauddiv_byte", rd, 32'h0312);
    applyStimulus(R_BAUDDIV, 32'hFFFF_0004, W_HALF);
    readReg(R_BAUDDIV, rd); checkOutput("bauddiv_half", rd, 4);

    // Single frame 0xA5 at 4 clocks per bit.
    base = startTimes.size();
    pushByte(8'hA5, 4, 1, 1);
    waitStarts(base + 1, 20);
    checkOutput("t1_start_latency", startTimes[base], lastWriteCycle + 1);
    checkOutput("t1_irq_busy", {31'd0, tx_irq}, 0);
    waitIdle(100);
    checkOutput("t1_irq_rise", cycle, startTimes[base] + 41);

    // Three queued bytes sent back-to-back.
    base = startTimes.size();
    applyStimulus(R_CTRL, 0, W_WORD);
    pushByte(8'h01, 4, 1, 1);
    pushByte(8'h02, 4, 1, 1);
    pushByte(8'h03, 4, 1, 1);
    readReg(R_STATUS, rd);  checkOutput("t2_count3", rd, 32'h0300);
    applyStimulus(R_CTRL, 1, W_WORD);
    @(negedge clk);
    readReg(R_STATUS, rd);  checkOutput("t2_count2", rd, 32'h0204);
    waitStarts(base + 2, 100);
    readReg(R_STATUS, rd);  checkOutput("t2_count1", rd, 32'h0104);
    waitStarts(base + 3, 100);
    readReg(R_STATUS, rd);  checkOutput("t2_count0", rd, 32'h0006);
    checkOutput("t2_gap12", startTimes[base + 1] - startTimes[base], 40);
    checkOutput("t2_gap23", startTimes[base + 2] - startTimes[base + 1], 40);
    waitIdle(100);
    checkOutput("t2_irq_rise", cycle, startTimes[base + 2] + 41);

    // Overflow with EN held low, then push in the same cycle as the first pop.
    applyStimulus(R_CTRL, 0, W_WORD);
    for (int i = 0; i < 17; i++) pushByte(8'(i * 37 + 5), 4, (i < 16), 1);
    readReg(R_STATUS, rd);  checkOutput("t3_full_ovf", rd, 32'h1009);
    applyStimulus(R_STATUS, 32'h8, W_WORD);
    readReg(R_STATUS, rd);  checkOutput("t3_ovf_clear", rd, 32'h1001);
    applyStimulus(R_CTRL, 1, W_WORD);
    pushByte(8'hEE, 4, 1, 1);
    readReg(R_STATUS, rd);  checkOutput("t4_push_pop_full", rd, 32'h1005);
    waitIdle(1000);

    // Divider change mid-frame only affects the next frame.
    base = startTimes.size();
    pushByte(8'h3C, 4, 1, 1);
    pushByte(8'hC3, 8, 1, 1);
    waitStarts(base + 1, 20);
    repeat (5) @(negedge clk);
    applyStimulus(R_BAUDDIV, 8, W_WORD);
    waitStarts(base + 2, 100);
    checkOutput("t5_frame1_len", startTimes[base + 1] - startTimes[base], 40);
    waitIdle(200);
    checkOutput("t5_frame2_len", cycle, startTimes[base + 1] + 81);

    // Reset during data bit 3 aborts the frame and flushes the FIFO.
    applyStimulus(R_BAUDDIV, 4, W_WORD);
    base = startTimes.size();
    pushByte(8'h5A, 4, 1, 0);
    pushByte(8'h77, 4, 0, 0);
    waitStarts(base + 1, 20);
    while (cycle < startTimes[base] + 17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_txd_high", {31'd0, uart_txd}, 1);
    rst = 1'b0;
    readReg(R_STATUS, rd);  checkOutput("t6_status", rd, 32'h0002);
    readReg(R_BAUDDIV, rd); checkOutput("t6_bauddiv", rd, 868);
    repeat (60) @(negedge clk);
    checkOutput("t6_no_more_frames", startTimes.size(), base + 1);
    checkOutput("sb_drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
